axis_tybec_bridge: RTL and testbench

Parametrised successor to the single-handshake AXI-Stream wrapper around TyBEC-generated `main`. It has N input channels, each with its own buffered AXI-Stream slave, so channels may arrive skewed in time. The channels are joined into the single ivalid/iready handshake the TyBEC kernel expects. A buffered master side absorbs kernel output and reports overflow; beat counters support host debug.

---
 rtl/axis_tybec_pkg.sv | 22 ++
 rtl/tybec_sync_fifo.sv | 55 +++++
 rtl/axis_tybec_bridge.sv | 92 +++++++++
 tb/tb_axis_tybec_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tybec_pkg.sv
// Shared constants, beat counter type and parameter legality helpers for the
// TyBEC multi-channel AXI-Stream bridge.
package axis_tybec_pkg;

  localparam int MAX_CHANNELS = 8;
  localparam int CNT_W        = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic bit is_pow2_ge2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // Data width is 32 bits per kernel vector lane, up to 16 lanes.
  function automatic bit params_legal(input int width, input int nch,
                                      input int in_depth, input int out_depth);
    return (width >= 32) && (width <= 512) && ((width % 32) == 0) &&
           (nch >= 1) && (nch <= MAX_CHANNELS) &&
           is_pow2_ge2(in_depth) && is_pow2_ge2(out_depth);
  endfunction

endpackage

// File: rtl/tybec_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive only from the
// occupancy register, so there is no push-to-pop bypass.
module tybec_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axis_tybec_bridge.sv
// Joins N independently buffered AXI-Stream inputs into one TyBEC kernel
// handshake and buffers kernel output onto an AXI-Stream master.
module axis_tybec_bridge
  import axis_tybec_pkg::*;
#(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_IN_DEPTH     = 2,
  parameter int C_OUT_DEPTH    = 4
) (
  input  logic                                         aclk,
  input  logic                                         areset,
  input  logic [C_NUM_CHANNELS-1:0]                    s_tvalid,
  input  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  s_tdata,
  output logic [C_NUM_CHANNELS-1:0]                    s_tready,
  output logic                                         k_ivalid,
  output logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0]  k_idata,
  input  logic                                         k_iready,
  input  logic                                         k_ovalid,
  input  logic [C_DATA_WIDTH-1:0]                      k_odata,
  output logic                                         k_oready,
  output logic                                         m_tvalid,
  output logic [C_DATA_WIDTH-1:0]                      m_tdata,
  input  logic                                         m_tready,
  output cnt_t                                         in_beats,
  output cnt_t                                         out_beats,
  output logic                                         err_overflow
);

  if (!params_legal(C_DATA_WIDTH, C_NUM_CHANNELS, C_IN_DEPTH, C_OUT_DEPTH)) begin : g_bad_params
    $error("axis_tybec_bridge: illegal width, channel count or FIFO depth");
  end

  logic [C_NUM_CHANNELS-1:0] in_full;
  logic [C_NUM_CHANNELS-1:0] in_empty;
  logic                      join_fire;
  logic                      out_full;
  logic                      out_empty;
  logic                      out_fire;

  assign s_tready  = ~in_full;
  assign k_ivalid  = ~|in_empty;
  assign join_fire = k_ivalid & k_iready;

  for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_in_fifo
    tybec_sync_fifo #(
      .WIDTH (C_DATA_WIDTH),
      .DEPTH (C_IN_DEPTH)
    ) u_in_fifo (
      .aclk   (aclk),
      .areset (areset),
      .push   (s_tvalid[i]),
      .din    (s_tdata[i]),
      .pop    (join_fire),
      .full   (in_full[i]),
      .empty  (in_empty[i]),
      .head   (k_idata[i])
    );
  end

  tybec_sync_fifo #(
    .WIDTH (C_DATA_WIDTH),
    .DEPTH (C_OUT_DEPTH)
  ) u_out_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (k_ovalid),
    .din    (k_odata),
    .pop    (m_tready),
    .full   (out_full),
    .empty  (out_empty),
    .head   (m_tdata)
  );

  assign k_oready = ~out_full;
  assign m_tvalid = ~out_empty;
  assign out_fire = m_tvalid & m_tready;

  // Kernel output arriving while the output FIFO is full is lost; remember it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      in_beats     <= '0;
      out_beats    <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (join_fire)           in_beats     <= in_beats + cnt_t'(1);
      if (out_fire)            out_beats    <= out_beats + cnt_t'(1);
      if (k_ovalid & out_full) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_tybec_bridge.sv
// Self-checking bench: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axis_tybec_bridge;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int ID = 2;
  localparam int OD = 4;

  logic                 aclk = 1'b0;
  logic                 areset;
  logic [N-1:0]         s_tvalid;
  logic [N-1:0][W-1:0]  s_tdata;
  logic [N-1:0]         s_tready;
  logic                 k_ivalid;
  logic [N-1:0][W-1:0]  k_idata;
  logic                 k_iready;
  logic                 k_ovalid;
  logic [W-1:0]         k_odata;
  logic                 k_oready;
  logic                 m_tvalid;
  logic [W-1:0]         m_tdata;
  logic                 m_tready;
  logic [31:0]          in_beats;
  logic [31:0]          out_beats;
  logic                 err_overflow;

  // kmode=0: kernel echoes each accepted tuple as the sum of its lanes in the
  // same cycle; kmode=1: kernel output is driven directly by the bench.
  logic                 kmode;
  logic                 kv;
  logic [W-1:0]         kd;

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  function automatic logic [W-1:0] kern(input logic [N-1:0][W-1:0] t);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + t[i];
    return s;
  endfunction

  assign k_ovalid = kmode ? kv : (k_ivalid & k_iready);
  assign k_odata  = kmode ? kd : kern(k_idata);

  axis_tybec_bridge #(
    .C_DATA_WIDTH   (W),
    .C_NUM_CHANNELS (N),
    .C_IN_DEPTH     (ID),
    .C_OUT_DEPTH    (OD)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_tvalid     (s_tvalid),
    .s_tdata      (s_tdata),
    .s_tready     (s_tready),
    .k_ivalid     (k_ivalid),
    .k_idata      (k_idata),
    .k_iready     (k_iready),
    .k_ovalid     (k_ovalid),
    .k_odata      (k_odata),
    .k_oready     (k_oready),
    .m_tvalid     (m_tvalid),
    .m_tdata      (m_tdata),
    .m_tready     (m_tready),
    .in_beats     (in_beats),
    .out_beats    (out_beats),
    .err_overflow (err_overflow)
  );

  // Reference model: plain queues and counters.
  logic [W-1:0] q_in [N][$];
  logic [W-1:0] q_out [$];
  logic [31:0]  m_in  = 0;
  logic [31:0]  m_out = 0;
  logic         m_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit                  join_ok;
    bit                  kfire;
    bit                  kov;
    bit                  opop;
    bit                  ofull;
    bit                  push_ok [N];
    logic [W-1:0]        kod;
    logic [N-1:0][W-1:0] t;
    if (areset) begin
      for (int i = 0; i < N; i++) q_in[i].delete();
      q_out.delete();
      m_in  = 0;
      m_out = 0;
      m_err = 0;
      return;
    end
    join_ok = 1;
    t = '0;
    for (int i = 0; i < N; i++) if (q_in[i].size() == 0) join_ok = 0;
    if (join_ok) for (int i = 0; i < N; i++) t[i] = q_in[i][0];
    kfire = join_ok && k_iready;
    kov   = kmode ? kv : kfire;
    kod   = kmode ? kd : kern(t);
    opop  = (q_out.size() > 0) && m_tready;
    ofull = (q_out.size() == OD);
    for (int i = 0; i < N; i++) push_ok[i] = s_tvalid[i] && (q_in[i].size() < ID);
    for (int i = 0; i < N; i++) begin
      if (kfire) void'(q_in[i].pop_front());
      if (push_ok[i]) q_in[i].push_back(s_tdata[i]);
    end
    if (opop) void'(q_out.pop_front());
    if (kov) begin
      if (!ofull) q_out.push_back(kod);
      else        m_err = 1;
    end
    if (kfire) m_in  = m_in + 1;
    if (opop)  m_out = m_out + 1;
  endtask

  task automatic compare();
    bit                  jv;
    logic [N-1:0][W-1:0] t;
    jv = 1;
    t = '0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("s_tready[%0d]", i), s_tready[i], q_in[i].size() < ID);
      if (q_in[i].size() == 0) jv = 0;
      else t[i] = q_in[i][0];
    end
    chk("k_ivalid", k_ivalid, jv);
    if (jv) chk("k_idata", k_idata, t);
    chk("k_oready", k_oready, q_out.size() < OD);
    chk("m_tvalid", m_tvalid, q_out.size() > 0);
    if (q_out.size() > 0) chk("m_tdata", m_tdata, q_out[0]);
    chk("in_beats", in_beats, m_in);
    chk("out_beats", out_beats, m_out);
    chk("err_overflow", err_overflow, m_err);
  endtask

  task automatic step();
    @(posedge aclk);
    model_update();
    @(negedge aclk);
    compare();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] got [$];
    int           sent;
    int           cyc;
    bit           acc0;
    bit           acc1;

    areset = 1; s_tvalid = '0; s_tdata = '0; k_iready = 0; m_tready = 0;
    kmode = 0; kv = 0; kd = '0;
    @(negedge aclk);
    step(); step();
    areset = 0;
    step();

    // Reset / idle
    chk("rst_s_tready", s_tready, 2'b11);
    chk("rst_k_oready", k_oready, 1'b1);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_k_ivalid", k_ivalid, 1'b0);
    chk("rst_in_beats", in_beats, 32'd0);
    chk("rst_out_beats", out_beats, 32'd0);

    // Skew: ch0 at cycle 0, ch1 at cycle 3
    k_iready = 1; m_tready = 1;
    s_tvalid = 2'b01; s_tdata[0] = 32'hA;
    step();
    s_tvalid = 2'b00;
    step(); step();
    chk("skew_not_yet", k_ivalid, 1'b0);
    s_tvalid = 2'b10; s_tdata[1] = 32'hB;
    step();
    s_tvalid = 2'b00;
    chk("skew_k_ivalid", k_ivalid, 1'b1);
    chk("skew_k_idata", k_idata, 64'h0000000B_0000000A);
    step();
    chk("skew_in_beats", in_beats, 32'd1);
    chk("skew_m_tvalid", m_tvalid, 1'b1);
    chk("skew_m_tdata", m_tdata, 32'h15);
    step();
    chk("skew_out_beats", out_beats, 32'd1);

    // Back-pressure on channel 0
    k_iready = 0;
    s_tvalid = 2'b01; s_tdata[0] = 32'd1;
    step();
    s_tdata[0] = 32'd2;
    step();
    chk("bp_full_ready", s_tready, 2'b10);
    s_tdata[0] = 32'd3;
    step(); step();
    chk("bp_held_ready0", s_tready[0], 1'b0);
    chk("bp_ready1", s_tready[1], 1'b1);
    s_tvalid = 2'b11; s_tdata[1] = 32'h10; k_iready = 1;
    for (int c = 0; c < 12; c++) begin
      if (m_tvalid && m_tready) got.push_back(m_tdata);
      acc0 = s_tvalid[0] && (q_in[0].size() < ID);
      acc1 = s_tvalid[1] && (q_in[1].size() < ID);
      step();
      if (acc0) s_tvalid[0] = 1'b0;
      if (acc1) begin
        if (s_tdata[1] == 32'h12) s_tvalid[1] = 1'b0;
        else s_tdata[1] = s_tdata[1] + 1;
      end
    end
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_out0", got[0], 32'h11);
      chk("bp_out1", got[1], 32'h13);
      chk("bp_out2", got[2], 32'h15);
    end
    chk("bp_in_beats", in_beats, 32'd4);
    chk("bp_out_beats", out_beats, 32'd4);

    // Output FIFO overflow
    k_iready = 0; s_tvalid = '0; m_tready = 0; kmode = 1;
    for (int i = 0; i < 5; i++) begin
      kv = 1; kd = 32'd100 + 32'(i);
      step();
      if (i == 3) chk("ovf_k_oready", k_oready, 1'b0);
    end
    kv = 0; kmode = 0;
    chk("ovf_err", err_overflow, 1'b1);
    m_tready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", m_tdata, 32'd100 + 32'(i));
      step();
    end
    chk("ovf_out_beats", out_beats, 32'd8);
    chk("ovf_drained", m_tvalid, 1'b0);

    // Reset with two tuples buffered
    k_iready = 0; m_tready = 0;
    s_tvalid = 2'b11; s_tdata[0] = 32'h21; s_tdata[1] = 32'h31;
    step();
    s_tdata[0] = 32'h22; s_tdata[1] = 32'h32;
    step();
    s_tvalid = '0;
    chk("mid_loaded", k_ivalid, 1'b1);
    areset = 1;
    step();
    chk("mid_s_tready", s_tready, 2'b11);
    chk("mid_k_ivalid", k_ivalid, 1'b0);
    chk("mid_in_beats", in_beats, 32'd0);
    chk("mid_out_beats", out_beats, 32'd0);
    chk("mid_err", err_overflow, 1'b0);
    areset = 0; m_tready = 1; k_iready = 1;
    step(); step();
    chk("mid_no_stale_m", m_tvalid, 1'b0);
    chk("mid_no_stale_k", k_ivalid, 1'b0);

    // Streaming 1000 tuples
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 3000) begin
      s_tvalid = 2'b11;
      s_tdata[0] = $urandom; s_tdata[1] = $urandom;
      acc0 = (q_in[0].size() < ID) && (q_in[1].size() < ID);
      step();
      cyc++;
      if (acc0) sent++;
    end
    s_tvalid = '0;
    chk("stream_cycles", cyc, 1000);
    for (int c = 0; c < 5; c++) step();
    chk("stream_in_beats", in_beats, 32'd1000);
    chk("stream_out_beats", out_beats, 32'd1000);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      areset   = ($urandom_range(0, 499) == 0);
      s_tvalid = N'($urandom);
      s_tdata[0] = $urandom; s_tdata[1] = $urandom;
      k_iready = ($urandom_range(0, 3) != 0);
      m_tready = ($urandom_range(0, 2) != 0);
      kmode    = ($urandom_range(0, 7) == 0);
      kv       = $urandom_range(0, 1);
      kd       = $urandom;
      step();
    end
    areset = 0; s_tvalid = '0; kmode = 0; k_iready = 1; m_tready = 1;
    for (int c = 0; c < 10; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
